// File: rtl/aiv_timing_pkg.sv
// aiv_timing_pkg
//   Shared AIV 625-line interlaced timing constants, counter widths and the
//   field type. Used by the transmit sync generator and the input tracker.
package aiv_timing_pkg;

   // Frame geometry (dots at 13.5 MHz, clk at 81 MHz)
   localparam int unsigned CLK_DIV         = 6;
   localparam int unsigned H_TOTAL         = 864;
   localparam int unsigned V_TOTAL_ODD     = 313;
   localparam int unsigned V_TOTAL_EVEN    = 312;
   localparam int unsigned ACTIVE_H_START  = 72;
   localparam int unsigned ACTIVE_H_WIDTH  = 720;
   localparam int unsigned ACTIVE_V_START  = 23;
   localparam int unsigned ACTIVE_V_HEIGHT = 288;
   localparam int unsigned HSYNC_WIDTH     = 64;
   localparam int unsigned VSYNC_WIDTH     = 3;

   // Counter widths
   localparam int unsigned DIV_W   = 3;
   localparam int unsigned DOT_W   = 10;
   localparam int unsigned LINE_W  = 9;
   localparam int unsigned COORD_W = 10;

   typedef enum logic {
      FieldEven = 1'b0,
      FieldOdd  = 1'b1
   } field_e;

   function automatic field_e toggle_field(input field_e f);
      return (f == FieldOdd) ? FieldEven : FieldOdd;
   endfunction

endpackage

// File: rtl/aiv_dot_ce_divider.sv
// aiv_dot_ce_divider
//   clk-to-dot divider. Counts 0..ClkDiv-1 while enabled and flags the clk on
//   which the dot counter must advance.
// Ports:
//   clk      in   81 MHz clock
//   nReset   in   asynchronous active-low reset
//   enable   in   1 = count, 0 = hold
//   restart  in   synchronous clear, overrides enable
//   clk_div  out  current divider count
//   dot_tick out  combinational: dot advances on this clk edge
module aiv_dot_ce_divider
   import aiv_timing_pkg::*;
#(
   parameter int unsigned ClkDiv = CLK_DIV
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             enable,
   input  logic             restart,
   output logic [DIV_W-1:0] clk_div,
   output logic             dot_tick
);

   localparam logic [DIV_W-1:0] DivLast = DIV_W'(ClkDiv - 1);

   logic [DIV_W-1:0] div_q, div_d;

   always_comb begin
      div_d    = div_q;
      dot_tick = 1'b0;
      if (restart) begin
         div_d = '0;
      end else if (enable) begin
         if (div_q == DivLast) begin
            div_d    = '0;
            dot_tick = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign clk_div = div_q;

endmodule

// File: rtl/aiv_sync_generator.sv
// aiv_sync_generator
//   Transmit-side AIV timing source: dot/line/field counters for a 625-line
//   interlaced frame, registered sync strobes, video-level sync pulses,
//   blanking and active pixel coordinates. Every output is a register of the
//   counter state, so outputs lag the state by one clk.
// Ports:
//   clk            in   81 MHz clock
//   nReset         in   asynchronous active-low reset
//   enable         in   1 = run, 0 = freeze counters (strobes low)
//   restart        in   one-clk request: odd field, line 0, dot 0
//   hsync          out  one-clk strobe at line start
//   vsync          out  one-clk strobe at field start (one clk after hsync)
//   isFieldOdd     out  1 = odd field
//   dot_ce         out  one-clk dot enable
//   hsync_pulse_n  out  low for the first HsyncWidth dots of a line
//   vsync_pulse_n  out  low for the first VsyncWidth lines of a field
//   display_enable out  inside active window
//   active_dot     out  active dot index, 0 outside window
//   active_line    out  frame line 2*field_line+odd, 0 outside window
module aiv_sync_generator
   import aiv_timing_pkg::*;
#(
   parameter int unsigned ClkDiv        = CLK_DIV,
   parameter int unsigned HTotal        = H_TOTAL,
   parameter int unsigned VTotalOdd     = V_TOTAL_ODD,
   parameter int unsigned VTotalEven    = V_TOTAL_EVEN,
   parameter int unsigned ActiveHStart  = ACTIVE_H_START,
   parameter int unsigned ActiveHWidth  = ACTIVE_H_WIDTH,
   parameter int unsigned ActiveVStart  = ACTIVE_V_START,
   parameter int unsigned ActiveVHeight = ACTIVE_V_HEIGHT,
   parameter int unsigned HsyncWidth    = HSYNC_WIDTH,
   parameter int unsigned VsyncWidth    = VSYNC_WIDTH
) (
   input  logic               clk,
   input  logic               nReset,
   input  logic               enable,
   input  logic               restart,
   output logic               hsync,
   output logic               vsync,
   output logic               isFieldOdd,
   output logic               dot_ce,
   output logic               hsync_pulse_n,
   output logic               vsync_pulse_n,
   output logic               display_enable,
   output logic [COORD_W-1:0] active_dot,
   output logic [COORD_W-1:0] active_line
);

   localparam logic [DOT_W-1:0]  HLast     = DOT_W'(HTotal - 1);
   localparam logic [LINE_W-1:0] VOddLast  = LINE_W'(VTotalOdd - 1);
   localparam logic [LINE_W-1:0] VEvenLast = LINE_W'(VTotalEven - 1);
   localparam logic [DOT_W-1:0]  HsyncEnd  = DOT_W'(HsyncWidth);
   localparam logic [LINE_W-1:0] VsyncEnd  = LINE_W'(VsyncWidth);
   localparam logic [DOT_W-1:0]  AhStart   = DOT_W'(ActiveHStart);
   localparam logic [DOT_W-1:0]  AhEnd     = DOT_W'(ActiveHStart + ActiveHWidth);
   localparam logic [LINE_W-1:0] AvStart   = LINE_W'(ActiveVStart);
   localparam logic [LINE_W-1:0] AvEnd     = LINE_W'(ActiveVStart + ActiveVHeight);

   logic [DIV_W-1:0]  clk_div;
   logic              dot_tick;
   logic [DOT_W-1:0]  dot_q, dot_d;
   logic [LINE_W-1:0] line_q, line_d;
   field_e            field_q, field_d;
   logic [LINE_W-1:0] line_last;

   aiv_dot_ce_divider #(
      .ClkDiv (ClkDiv)
   ) u_div (
      .clk      (clk),
      .nReset   (nReset),
      .enable   (enable),
      .restart  (restart),
      .clk_div  (clk_div),
      .dot_tick (dot_tick)
   );

   // ---------------------------------------------------------------------
   // Dot / line / field counters
   // ---------------------------------------------------------------------
   assign line_last = (field_q == FieldOdd) ? VOddLast : VEvenLast;

   always_comb begin
      dot_d   = dot_q;
      line_d  = line_q;
      field_d = field_q;
      if (restart) begin
         dot_d   = '0;
         line_d  = '0;
         field_d = FieldOdd;
      end else if (dot_tick) begin
         if (dot_q == HLast) begin
            dot_d = '0;
            if (line_q == line_last) begin
               line_d  = '0;
               field_d = toggle_field(field_q);
            end else begin
               line_d = line_q + 1'b1;
            end
         end else begin
            dot_d = dot_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         dot_q   <= '0;
         line_q  <= '0;
         field_q <= FieldOdd;
      end else begin
         dot_q   <= dot_d;
         line_q  <= line_d;
         field_q <= field_d;
      end
   end

   // ---------------------------------------------------------------------
   // Output decode of the current state
   // ---------------------------------------------------------------------
   logic               hs_c, vs_c, hpn_c, vpn_c, de_c;
   logic [LINE_W-1:0]  line_rel;
   logic [COORD_W-1:0] ad_c, al_c;

   // vsync decodes clk_div == 1 so it lands one clk after the line-0 hsync
   assign hs_c     = (clk_div == '0) && (dot_q == '0);
   assign vs_c     = (clk_div == DIV_W'(1)) && (dot_q == '0) && (line_q == '0);
   assign hpn_c    = (dot_q >= HsyncEnd);
   assign vpn_c    = (line_q >= VsyncEnd);
   assign de_c     = (dot_q >= AhStart) && (dot_q < AhEnd) &&
                     (line_q >= AvStart) && (line_q < AvEnd);
   assign line_rel = line_q - AvStart;
   assign ad_c     = de_c ? (dot_q - AhStart) : '0;
   assign al_c     = de_c ? {line_rel, field_q == FieldOdd} : '0;

   logic               hsync_q, vsync_q, odd_q, dot_ce_q, hpn_q, vpn_q, de_q;
   logic [COORD_W-1:0] ad_q, al_q;

   // Outputs sample the pre-edge state. A frozen or restarting edge drops the
   // strobes and holds the levels, so a truncated line emits nothing.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         odd_q    <= 1'b0;
         dot_ce_q <= 1'b0;
         hpn_q    <= 1'b1;
         vpn_q    <= 1'b1;
         de_q     <= 1'b0;
         ad_q     <= '0;
         al_q     <= '0;
      end else if (restart || !enable) begin
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         dot_ce_q <= 1'b0;
      end else begin
         hsync_q  <= hs_c;
         vsync_q  <= vs_c;
         odd_q    <= (field_q == FieldOdd);
         dot_ce_q <= dot_tick;
         hpn_q    <= hpn_c;
         vpn_q    <= vpn_c;
         de_q     <= de_c;
         ad_q     <= ad_c;
         al_q     <= al_c;
      end
   end

   assign hsync          = hsync_q;
   assign vsync          = vsync_q;
   assign isFieldOdd     = odd_q;
   assign dot_ce         = dot_ce_q;
   assign hsync_pulse_n  = hpn_q;
   assign vsync_pulse_n  = vpn_q;
   assign display_enable = de_q;
   assign active_dot     = ad_q;
   assign active_line    = al_q;

endmodule

// File: tb/tb_aiv_sync_generator.sv
// tb_aiv_sync_generator
//   Runs a full-geometry instance and a scaled-down instance side by side on
//   the same stimulus. Expected outputs come from a frame-arithmetic model:
//   the number of enabled clks since reset/restart fixes dot, line and field.
module tb_aiv_sync_generator;

   // Scaled-down geometry so active video and both fields fit the run
   localparam int SmClkDiv = 3, SmHTotal = 20, SmVOdd = 7, SmVEven = 6;
   localparam int SmAhStart = 4, SmAhWidth = 12, SmAvStart = 2, SmAvHeight = 4;
   localparam int SmHsync = 3, SmVsync = 1;
   localparam int SmFrame = (SmVOdd + SmVEven) * SmHTotal * SmClkDiv;

   localparam int IHs = 0, IVs = 1, IOdd = 2, ICe = 3, IHpn = 4, IVpn = 5, IDe = 6;
   localparam int IAd = 7, IAl = 8;

   typedef logic [8:0][9:0] out_t;
   typedef struct {
      int div, ht, vo, ve, ahs, ahw, avs, avh, hsw, vsw;
   } geo_t;

   logic clk = 1'b0;
   logic nReset = 1'b1;
   logic enable = 1'b0;
   logic restart = 1'b0;

   logic f_hs, f_vs, f_odd, f_ce, f_hpn, f_vpn, f_de;
   logic s_hs, s_vs, s_odd, s_ce, s_hpn, s_vpn, s_de;
   logic [9:0] f_ad, f_al, s_ad, s_al;

   aiv_sync_generator u_full (
      .clk(clk), .nReset(nReset), .enable(enable), .restart(restart),
      .hsync(f_hs), .vsync(f_vs), .isFieldOdd(f_odd), .dot_ce(f_ce),
      .hsync_pulse_n(f_hpn), .vsync_pulse_n(f_vpn), .display_enable(f_de),
      .active_dot(f_ad), .active_line(f_al)
   );

   aiv_sync_generator #(
      .ClkDiv(SmClkDiv), .HTotal(SmHTotal), .VTotalOdd(SmVOdd), .VTotalEven(SmVEven),
      .ActiveHStart(SmAhStart), .ActiveHWidth(SmAhWidth), .ActiveVStart(SmAvStart),
      .ActiveVHeight(SmAvHeight), .HsyncWidth(SmHsync), .VsyncWidth(SmVsync)
   ) u_small (
      .clk(clk), .nReset(nReset), .enable(enable), .restart(restart),
      .hsync(s_hs), .vsync(s_vs), .isFieldOdd(s_odd), .dot_ce(s_ce),
      .hsync_pulse_n(s_hpn), .vsync_pulse_n(s_vpn), .display_enable(s_de),
      .active_dot(s_ad), .active_line(s_al)
   );

   always #5 clk = ~clk;

   out_t got_f, got_s;
   always_comb begin
      got_f = '0;
      got_f[IHs][0] = f_hs;   got_f[IVs][0] = f_vs;   got_f[IOdd][0] = f_odd;
      got_f[ICe][0] = f_ce;   got_f[IHpn][0] = f_hpn; got_f[IVpn][0] = f_vpn;
      got_f[IDe][0] = f_de;   got_f[IAd] = f_ad;      got_f[IAl] = f_al;
      got_s = '0;
      got_s[IHs][0] = s_hs;   got_s[IVs][0] = s_vs;   got_s[IOdd][0] = s_odd;
      got_s[ICe][0] = s_ce;   got_s[IHpn][0] = s_hpn; got_s[IVpn][0] = s_vpn;
      got_s[IDe][0] = s_de;   got_s[IAd] = s_ad;      got_s[IAl] = s_al;
   end

   geo_t g_f = '{div: 6, ht: 864, vo: 313, ve: 312, ahs: 72, ahw: 720, avs: 23, avh: 288,
                 hsw: 64, vsw: 3};
   geo_t g_s = '{div: SmClkDiv, ht: SmHTotal, vo: SmVOdd, ve: SmVEven, ahs: SmAhStart,
                 ahw: SmAhWidth, avs: SmAvStart, avh: SmAvHeight, hsw: SmHsync, vsw: SmVsync};

   int   tests = 0;
   int   fails = 0;
   int   n = 0;        // enabled clks since reset/restart
   int   en_clk = 0;   // enabled clks overall
   bit   adv;
   out_t e_f, e_s;

   int   last_hs_f, last_hs_s, hs_cnt_s, de_cnt_s;
   bit   vs_valid_s, prev_odd_s;

   function automatic string sig_name(input int i);
      case (i)
         IHs:     return "hsync";
         IVs:     return "vsync";
         IOdd:    return "isFieldOdd";
         ICe:     return "dot_ce";
         IHpn:    return "hsync_pulse_n";
         IVpn:    return "vsync_pulse_n";
         IDe:     return "display_enable";
         IAd:     return "active_dot";
         default: return "active_line";
      endcase
   endfunction

   function automatic out_t reset_out();
      out_t o = '0;
      o[IHpn] = 10'd1;
      o[IVpn] = 10'd1;
      return o;
   endfunction

   // Outputs one clk after the state reached by n enabled clks
   function automatic out_t model(input int cnt, input geo_t g);
      out_t o;
      int   div, dots, dot, fl, line;
      bit   odd, de;
      div  = cnt % g.div;
      dots = cnt / g.div;
      dot  = dots % g.ht;
      fl   = (dots / g.ht) % (g.vo + g.ve);
      odd  = (fl < g.vo);
      line = odd ? fl : fl - g.vo;
      de   = (dot >= g.ahs) && (dot < g.ahs + g.ahw) && (line >= g.avs) &&
             (line < g.avs + g.avh);
      o[IHs]  = 10'(div == 0 && dot == 0);
      o[IVs]  = 10'(div == 1 && dot == 0 && line == 0);
      o[IOdd] = 10'(odd);
      o[ICe]  = 10'(div == g.div - 1);
      o[IHpn] = 10'(dot >= g.hsw);
      o[IVpn] = 10'(line >= g.vsw);
      o[IDe]  = 10'(de);
      o[IAd]  = de ? 10'(dot - g.ahs) : 10'd0;
      o[IAl]  = de ? 10'(2 * (line - g.avs) + int'(odd)) : 10'd0;
      return o;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_inst(input string inst, input out_t got, input out_t exp);
      for (int i = 0; i < 9; i++) begin
         check_eq($sformatf("%s.%s", inst, sig_name(i)), 32'(got[i]), 32'(exp[i]));
      end
   endtask

   task automatic clear_trk();
      last_hs_f  = -1;
      last_hs_s  = -1;
      hs_cnt_s   = 0;
      de_cnt_s   = 0;
      vs_valid_s = 1'b0;
   endtask

   task automatic clear_strobes();
      e_f[IHs] = '0; e_f[IVs] = '0; e_f[ICe] = '0;
      e_s[IHs] = '0; e_s[IVs] = '0; e_s[ICe] = '0;
   endtask

   // One clk: update the model at the edge, compare at the falling edge
   task automatic cycle();
      @(posedge clk);
      adv = 1'b0;
      if (!nReset) begin
         e_f = reset_out();
         e_s = reset_out();
         n   = 0;
         clear_trk();
      end else if (restart) begin
         clear_strobes();
         n = 0;
         clear_trk();
      end else if (enable) begin
         e_f = model(n, g_f);
         e_s = model(n, g_s);
         n++;
         en_clk++;
         adv = 1'b1;
      end else begin
         clear_strobes();
      end
      @(negedge clk);
      check_inst("full", got_f, e_f);
      check_inst("small", got_s, e_s);
      if (adv && s_de === 1'b1) de_cnt_s++;
      if (f_hs === 1'b1) begin
         if (last_hs_f >= 0) check_eq("full.hsync_period", en_clk - last_hs_f, 5184);
         last_hs_f = en_clk;
      end
      if (s_hs === 1'b1) begin
         if (last_hs_s >= 0)
            check_eq("small.hsync_period", en_clk - last_hs_s, SmHTotal * SmClkDiv);
         check_eq("small.de_clks_per_line",
                  32'(de_cnt_s == 0 || de_cnt_s == SmAhWidth * SmClkDiv), 1);
         last_hs_s = en_clk;
         de_cnt_s  = 0;
         hs_cnt_s++;
      end
      if (s_vs === 1'b1) begin
         if (vs_valid_s) begin
            check_eq("small.lines_per_field", hs_cnt_s, prev_odd_s ? SmVOdd : SmVEven);
            check_eq("small.field_toggle", 32'(s_odd), 32'(!prev_odd_s));
         end
         vs_valid_s = 1'b1;
         prev_odd_s = s_odd;
         hs_cnt_s   = 0;
      end
   endtask

   task automatic startup_checks();
      nReset  = 1'b1;
      enable  = 1'b1;
      restart = 1'b0;
      cycle();
      check_eq("full.first_hsync", 32'(f_hs), 1);
      check_eq("full.first_odd", 32'(f_odd), 1);
      cycle();
      check_eq("full.first_vsync", 32'(f_vs), 1);
      check_eq("full.vsync_apart_from_hsync", 32'(f_hs), 0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      e_f = reset_out();
      e_s = reset_out();
      clear_trk();
      #1 nReset = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      startup_checks();

      // Freeze 50 clks at dot 400 of the second full-geometry line
      while (n < 5184 + 400 * 6) cycle();
      enable = 1'b0;
      for (int i = 0; i < 50; i++) cycle();
      enable = 1'b1;
      for (int i = 0; i < 20000; i++) cycle();

      // Restart mid-line 3 of the small instance's even field
      for (int i = 0; i < 2 * SmFrame && !((n % SmFrame) >= 600 && (n % SmFrame) < 660); i++)
         cycle();
      check_eq("small.reached_even_line3", 32'((n % SmFrame) >= 600 && (n % SmFrame) < 660), 1);
      check_eq("small.even_before_restart", 32'(s_odd), 0);
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      cycle();
      check_eq("small.restart_hsync", 32'(s_hs), 1);
      check_eq("small.restart_odd", 32'(s_odd), 1);
      cycle();
      check_eq("small.restart_vsync", 32'(s_vs), 1);

      // Restart held for several clks
      for (int i = 0; i < 200; i++) cycle();
      restart = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      restart = 1'b0;
      cycle();
      check_eq("small.held_restart_hsync", 32'(s_hs), 1);

      // Random enable gaps and sporadic restarts
      for (int i = 0; i < 30000; i++) begin
         enable  = ($urandom_range(0, 15) != 0);
         restart = ($urandom_range(0, 1499) == 0);
         cycle();
      end
      restart = 1'b0;
      enable  = 1'b1;

      // Asynchronous reset while the small instance is in active video
      for (int i = 0; i < SmFrame && e_s[IDe] != 10'd1; i++) cycle();
      check_eq("small.reached_active", 32'(s_de), 1);
      #2 nReset = 1'b0;
      #1;
      e_f = reset_out();
      e_s = reset_out();
      n   = 0;
      clear_trk();
      check_inst("full_async", got_f, e_f);
      check_inst("small_async", got_s, e_s);
      for (int i = 0; i < 2; i++) cycle();
      startup_checks();
      for (int i = 0; i < 2000; i++) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aiv_sync_generator.md
Name: aiv_sync_generator

Overview:
Transmit-side AIV timing source. It divides the 81 MHz clk into a 13.5 MHz dot enable and counts dots, lines and fields of a 625-line interlaced frame. It emits single-clk hsync/vsync strobes and a field-parity flag, plus video-level sync pulses, blanking and active pixel coordinates. It drives the AIV output path (overlay/pixel fetch) and the local loopback into the AIV input tracker.

Parameters:
CLK_DIV, 6, clk cycles per dot (81 MHz / 13.5 MHz)
H_TOTAL, 864, dots per line (0..863)
V_TOTAL_ODD, 313, lines in odd field (first field after reset)
V_TOTAL_EVEN, 312, lines in even field
ACTIVE_H_START, 72, first active dot
ACTIVE_H_WIDTH, 720, active dots per line
ACTIVE_V_START, 23, first active line of field
ACTIVE_V_HEIGHT, 288, active lines per field
HSYNC_WIDTH, 64, hsync_pulse_n low duration in dots
VSYNC_WIDTH, 3, vsync_pulse_n low duration in lines

Ports:
clk  in  1  81 MHz clock
nReset  in  1  asynchronous active-low reset
enable  in  1  1 = run; 0 = freeze all counters
restart  in  1  synchronous one-clk request: restart at odd field, line 0, dot 0
hsync  out  1  one-clk strobe at start of every line
vsync  out  1  one-clk strobe at start of every field
isFieldOdd  out  1  1 = odd field, 0 = even field
dot_ce  out  1  one-clk dot enable, every CLK_DIV clks
hsync_pulse_n  out  1  video-level line sync, low for HSYNC_WIDTH dots from dot 0
vsync_pulse_n  out  1  video-level field sync, low for lines 0..VSYNC_WIDTH-1
display_enable  out  1  1 inside active window
active_dot  out  10  0..719 when display_enable, else 0
active_line  out  10  frame line, 2*field_line+isFieldOdd when active, else 0

Behaviour:
- Reset (nReset low, async): clk_div = 0, dot = 0, line = 0, field = odd. All outputs 0, except hsync_pulse_n = 1, vsync_pulse_n = 1, isFieldOdd = 0.
- Internal state: clk_div 0..CLK_DIV-1, dot 0..H_TOTAL-1, line 0..V_TOTAL-1 (V_TOTAL selected by field), field bit.
- enable = 1: clk_div increments each clk and wraps at CLK_DIV-1. On wrap, dot increments. Dot wrap increments line. Line wrap at V_TOTAL_ODD or V_TOTAL_EVEN (by current field) toggles field.
- enable = 0: all counters hold; hsync, vsync and dot_ce held low; level outputs hold their value.
- All outputs are registered from counter state: 1 clk latency, no combinational paths from inputs.
- dot_ce = 1 in the clk following each state with clk_div == CLK_DIV-1.
- hsync = 1 for exactly one clk, in the clk following a state with clk_div == 0 and dot == 0.
- vsync = 1 for exactly one clk, in the clk following a state with clk_div == 1, dot == 0, line == 0. It is therefore one clk after that line's hsync and never coincident with hsync.
- isFieldOdd: registered copy of field; it changes in the same clk as the line-0 hsync.
- hsync_pulse_n = 0 while dot < HSYNC_WIDTH.
- vsync_pulse_n = 0 while line < VSYNC_WIDTH.
- display_enable = 1 iff ACTIVE_H_START <= dot < ACTIVE_H_START+ACTIVE_H_WIDTH and ACTIVE_V_START <= line < ACTIVE_V_START+ACTIVE_V_HEIGHT.
- active_dot = dot - ACTIVE_H_START. active_line = 2*(line - ACTIVE_V_START) + field_odd, computed at 10 bits, range 0..575.
- The odd field's extra line (312) is outside the active window.
- restart = 1 (takes priority over enable): next state is clk_div = 0, dot = 0, line = 0, field = odd.
  - hsync then fires the clk after that state; vsync the clk after hsync (enable permitting).
  - A restart within a line truncates it; no partial-line strobes are emitted.
- restart is held while asserted for multiple clks; resumes on deassert.
- Reset mid-line: outputs go to reset values immediately; no glitch pulses on release.
- Period checks: hsync every H_TOTAL*CLK_DIV = 5184 clks; vsync alternately every 313*5184 and 312*5184 clks.

Decomposition:
- Shared package aiv_timing_pkg: H_TOTAL, V_TOTAL_ODD/EVEN, ACTIVE_H_START/WIDTH, ACTIVE_V_START/HEIGHT, CLK_DIV.
- The input tracker uses the same constants from this package.
- One sub-module: aiv_dot_ce_divider (clk_div counter with enable/restart, produces the dot tick).

Test Plan:
- Release reset, enable = 1: first hsync at clk 1, first vsync at clk 2, dot_ce every 6 clks, isFieldOdd = 1 at clk 1.
- Measure hsync spacing = 5184 clks. Count 313 hsyncs in the first field and 312 in the second. isFieldOdd toggles 1→0→1.
- Count display_enable clks per active line = 720*6 = 4320.
  - active_dot runs 0..719.
  - First active line of odd field has active_line = 1; even field has 0; last is 575 (odd) and 574 (even).
  - Zero active lines within field lines 0..22.
- hsync_pulse_n low for 64*6 = 384 clks per line. vsync_pulse_n low for 3*5184 clks per field.
- Pulse restart mid-line 100 of even field: next hsync 1 clk after the restart state, vsync 1 clk later, isFieldOdd = 1, line count restarts.
- Drop enable for 50 clks at dot 400: strobes absent, counters frozen. The next hsync is delayed by exactly 50 clks.
- Assert nReset mid-active: display_enable, active_dot and active_line go to 0 asynchronously. Sequence restarts as in the first scenario.
